// File: rtl/acl_pkg.sv
// Shared opcodes, register map, reset values and FSM states for the accelerometer SPI slave.
package acl_pkg;

    localparam logic [7:0] OP_WRITE        = 8'h0A;
    localparam logic [7:0] OP_READ         = 8'h0B;

    localparam logic [7:0] ADDR_DEVID      = 8'h00;
    localparam logic [7:0] ADDR_XDATA      = 8'h08;
    localparam logic [7:0] ADDR_YDATA      = 8'h09;
    localparam logic [7:0] ADDR_FILTER_CTL = 8'h2C;
    localparam logic [7:0] ADDR_POWER_CTL  = 8'h2D;

    localparam logic [7:0] FILTER_CTL_RST  = 8'h13;
    localparam logic [7:0] POWER_CTL_RST   = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } acl_state_e;

    function automatic logic [7:0] acl_read_mux(
        input logic [7:0] addr,
        input logic [7:0] devid,
        input logic [7:0] x_snap,
        input logic [7:0] y_snap,
        input logic [7:0] filter_ctl,
        input logic [7:0] power_ctl
    );
        logic [7:0] value;
        case (addr)
            ADDR_DEVID:      value = devid;
            ADDR_XDATA:      value = x_snap;
            ADDR_YDATA:      value = y_snap;
            ADDR_FILTER_CTL: value = filter_ctl;
            ADDR_POWER_CTL:  value = power_ctl;
            default:         value = 8'h00;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous SPI line, with one-clk rise/fall pulses.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain_q, chain_d;
    logic              prev_q, prev_d;
    logic              sync;

    assign sync = chain_q[STAGES-1];

    always_comb begin
        chain_d = (chain_q << 1) | STAGES'(din);
        prev_d  = sync;
        rise    = sync & ~prev_q;
        fall    = ~sync & prev_q;
    end

    // Reset to 0 so a line already low at reset release never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

endmodule

// File: rtl/acl_spi_slave.sv
// SPI mode-0 register slave for an accelerometer front end (ID, X/Y snapshots, two control regs).
// Define ACL_ADDR_AUTOINC_EN to advance the address pointer after every completed data byte.
module acl_spi_slave
    import acl_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEVID       = 8'hAD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] x_sample,
    input  logic [7:0] y_sample,
    output logic [7:0] filter_ctl,
    output logic [7:0] power_ctl,
    output logic       wr_strobe
);

    logic sck_rise, sck_fall, ss_rise, ss_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (ss),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    // mosi goes through the same depth as sck so the sampled bit lines up with the detected rise.
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   mosi_bit;

    assign mosi_bit = mosi_sync_q[SYNC_STAGES-1];

    acl_state_e state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_in_q, shift_in_d;
    logic [7:0] shift_out_q, shift_out_d;
    logic       is_read_q, is_read_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] x_snap_q, x_snap_d;
    logic [7:0] y_snap_q, y_snap_d;
    logic [7:0] filter_q, filter_d;
    logic [7:0] power_q, power_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic       miso_q, miso_d;
    logic [7:0] rx_byte;
    logic [7:0] ptr_next;

`ifdef ACL_ADDR_AUTOINC_EN
    assign ptr_next = addr_q + 8'd1;
`else
    assign ptr_next = addr_q;
`endif

    always_comb begin
        mosi_sync_d = (mosi_sync_q << 1) | SYNC_STAGES'(mosi);
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        is_read_d   = is_read_q;
        addr_d      = addr_q;
        x_snap_d    = x_snap_q;
        y_snap_d    = y_snap_q;
        filter_d    = filter_q;
        power_d     = power_q;
        wr_strobe_d = 1'b0;
        rx_byte     = {shift_in_q[6:0], mosi_bit};

        // ss rise wins over a coincident 8th sck rise, so a cut-short byte never commits.
        if (ss_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
        end else if (ss_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
            x_snap_d  = x_sample;
            y_snap_d  = y_sample;
        end else begin
            case (state_q)
                ST_CMD: begin
                    if (sck_rise) begin
                        shift_in_d = rx_byte;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte == OP_WRITE) begin
                                state_d   = ST_ADDR;
                                is_read_d = 1'b0;
                            end else if (rx_byte == OP_READ) begin
                                state_d   = ST_ADDR;
                                is_read_d = 1'b1;
                            end else begin
                                state_d   = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        shift_in_d = rx_byte;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            addr_d  = rx_byte;
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (sck_rise) begin
                        shift_in_d = rx_byte;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (!is_read_q) begin
                                if (addr_q == ADDR_FILTER_CTL) begin
                                    filter_d    = rx_byte;
                                    wr_strobe_d = 1'b1;
                                end else if (addr_q == ADDR_POWER_CTL) begin
                                    power_d     = rx_byte;
                                    wr_strobe_d = 1'b1;
                                end
                            end
                            addr_d = ptr_next;
                        end
                    end
                    // A fall at a byte boundary loads the next byte; mid-byte falls shift.
                    if (sck_fall && is_read_q) begin
                        if (bit_cnt_q == 3'd0) begin
                            shift_out_d = acl_read_mux(addr_q, DEVID, x_snap_q, y_snap_q,
                                                       filter_q, power_q);
                        end else begin
                            shift_out_d = {shift_out_q[6:0], 1'b0};
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        miso_d = (state_d == ST_DATA && is_read_d) ? shift_out_d[7] : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_sync_q <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_in_q  <= 8'h00;
            shift_out_q <= 8'h00;
            is_read_q   <= 1'b0;
            addr_q      <= 8'h00;
            x_snap_q    <= 8'h00;
            y_snap_q    <= 8'h00;
            filter_q    <= FILTER_CTL_RST;
            power_q     <= POWER_CTL_RST;
            wr_strobe_q <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            is_read_q   <= is_read_d;
            addr_q      <= addr_d;
            x_snap_q    <= x_snap_d;
            y_snap_q    <= y_snap_d;
            filter_q    <= filter_d;
            power_q     <= power_d;
            wr_strobe_q <= wr_strobe_d;
            miso_q      <= miso_d;
        end
    end

    assign miso       = miso_q;
    assign filter_ctl = filter_q;
    assign power_ctl  = power_q;
    assign wr_strobe  = wr_strobe_q;

endmodule

// File: tb/tb_acl_spi_slave.sv
// Scoreboard bench for acl_spi_slave: a mode-0 SPI master pushes expected bytes/register
// states into queues, and independent monitors on miso and wr_strobe pop and compare.
`timescale 1ns/1ps
module tb_acl_spi_slave;

    localparam int HALF = 8;
`ifdef ACL_ADDR_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       ss  = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] x_sample = 8'h00;
    logic [7:0] y_sample = 8'h00;
    logic [7:0] filter_ctl;
    logic [7:0] power_ctl;
    logic       wr_strobe;

    int total = 0;
    int bad   = 0;

    // Reference state: the register file as the master believes it to be.
    logic [7:0]  m_filter = 8'h13;
    logic [7:0]  m_power  = 8'h00;
    logic [7:0]  exp_rd[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  tx_data[$];
    bit          frame_is_read = 1'b0;

    acl_spi_slave dut (
        .clk        (clk),
        .rst        (rst),
        .sck        (sck),
        .ss         (ss),
        .mosi       (mosi),
        .miso       (miso),
        .x_sample   (x_sample),
        .y_sample   (y_sample),
        .filter_ctl (filter_ctl),
        .power_ctl  (power_ctl),
        .wr_strobe  (wr_strobe)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [7:0] a, input logic [7:0] sx,
                                              input logic [7:0] sy);
        if (a == 8'h00) return 8'hAD;
        if (a == 8'h08) return sx;
        if (a == 8'h09) return sy;
        if (a == 8'h2C) return m_filter;
        if (a == 8'h2D) return m_power;
        return 8'h00;
    endfunction

    task automatic sendBit(input logic b);
        mosi = b;
        repeat (HALF) @(negedge clk);
        sck = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        #1;
        checkOutput("async_rst_filter", 32'(filter_ctl), 32'h13);
        checkOutput("async_rst_power", 32'(power_ctl), 32'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        m_filter = 8'h13;
        m_power  = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    // One ss frame: opcode, address, nbytes full data bytes, then optional partial bits
    // or an 8th bit whose sck rise coincides with ss rise.
    task automatic applyStimulus(input logic [7:0] op, input logic [7:0] addr, input int nbytes,
                                 input int tail_bits, input bit abort8, input bit wiggle);
        logic [7:0] ptr, sx, sy, d;
        logic [7:0] bytes[$];
        sx = x_sample;
        sy = y_sample;
        ptr = addr;
        frame_is_read = (op == 8'h0B);
        bytes = {op, addr};
        for (int k = 0; k < nbytes; k++) begin
            d = (k < tx_data.size()) ? tx_data[k] : 8'($urandom);
            bytes.push_back(d);
            if (op == 8'h0A) begin
                if (ptr == 8'h2C) begin
                    m_filter = d;
                    exp_wr.push_back({m_filter, m_power});
                end else if (ptr == 8'h2D) begin
                    m_power = d;
                    exp_wr.push_back({m_filter, m_power});
                end
            end else if (op == 8'h0B) begin
                exp_rd.push_back(model_read(ptr, sx, sy));
            end
            if (AUTOINC) ptr = ptr + 8'd1;
        end
        tx_data.delete();

        ss = 1'b0;
        repeat (HALF) @(negedge clk);
        foreach (bytes[i]) begin
            d = bytes[i];
            for (int b = 7; b >= 0; b--) begin
                sendBit(d[b]);
                if (wiggle && i == 0 && b == 7) begin
                    x_sample = x_sample ^ 8'h47;
                    y_sample = y_sample ^ 8'h47;
                end
            end
        end
        d = 8'($urandom);
        for (int b = 0; b < tail_bits; b++) sendBit(d[7-b]);
        if (abort8) begin
            for (int b = 0; b < 7; b++) sendBit(d[7-b]);
            mosi = d[0];
            repeat (HALF) @(negedge clk);
            sck = 1'b1;
            ss  = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end else begin
            repeat (HALF) @(negedge clk);
            ss = 1'b1;
        end
        repeat (3 * HALF) @(negedge clk);

        checkOutput("filter_ctl", 32'(filter_ctl), 32'(m_filter));
        checkOutput("power_ctl", 32'(power_ctl), 32'(m_power));
        checkOutput("miso_ss_high", 32'(miso), 32'h0);
        checkOutput("wr_pending", 32'(exp_wr.size()), 32'd0);
        checkOutput("rd_pending", 32'(exp_rd.size()), 32'd0);
        exp_wr.delete();
        exp_rd.delete();
    endtask

    // miso monitor: the first two bytes of a frame and every byte of a non-read frame must be 0.
    initial begin : miso_monitor
        logic [7:0] sh;
        logic [7:0] e;
        int nbits;
        forever begin
            @(negedge ss);
            nbits = 0;
            sh = 8'h00;
            forever begin
                @(posedge sck or posedge ss);
                if (ss === 1'b1) break;
                sh = {sh[6:0], miso};
                nbits++;
                if (nbits % 8 == 0) begin
                    if (nbits > 16 && frame_is_read) begin
                        if (exp_rd.size() == 0) begin
                            checkOutput("rd_queue", 32'(exp_rd.size()), 32'd1);
                        end else begin
                            e = exp_rd.pop_front();
                            checkOutput("miso_byte", 32'(sh), 32'(e));
                        end
                    end else begin
                        checkOutput("miso_quiet", 32'(sh), 32'h00);
                    end
                end
            end
        end
    end

    // wr_strobe monitor: every pulse must match the next expected register image.
    initial begin : strobe_monitor
        logic [15:0] w;
        forever begin
            @(negedge clk);
            if (wr_strobe === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    checkOutput("wr_strobe_unexpected", 32'(exp_wr.size()), 32'd1);
                end else begin
                    w = exp_wr.pop_front();
                    checkOutput("wr_regs", 32'({filter_ctl, power_ctl}), 32'(w));
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [7:0] op, a;
        logic [7:0] addrs[8];
        int r;
        addrs = '{8'h00, 8'h08, 8'h09, 8'h2C, 8'h2D, 8'h2B, 8'hFF, 8'h05};

        repeat (3) @(negedge clk);
        checkOutput("rst_filter", 32'(filter_ctl), 32'h13);
        checkOutput("rst_power", 32'(power_ctl), 32'h00);
        checkOutput("rst_miso", 32'(miso), 32'h0);
        checkOutput("rst_wr_strobe", 32'(wr_strobe), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        tx_data = {8'h17};
        applyStimulus(8'h0A, 8'h2C, 1, 0, 1'b0, 1'b0);
        tx_data = {8'h02};
        applyStimulus(8'h0A, 8'h2D, 1, 0, 1'b0, 1'b0);

        x_sample = 8'h12;
        y_sample = 8'h34;
        applyStimulus(8'h0B, 8'h08, 2, 0, 1'b0, 1'b0);
        applyStimulus(8'h0B, 8'h00, 1, 0, 1'b0, 1'b0);
        applyStimulus(8'h0B, 8'h05, 1, 0, 1'b0, 1'b0);

        x_sample = 8'h12;
        applyStimulus(8'h0B, 8'h08, 1, 0, 1'b0, 1'b1);
        checkOutput("x_changed", 32'(x_sample), 32'h55);

        resetDut();
        applyStimulus(8'h0A, 8'h2C, 0, 5, 1'b0, 1'b0);
        applyStimulus(8'h0A, 8'h2D, 0, 0, 1'b1, 1'b0);

        applyStimulus(8'h55, 8'h2C, 2, 0, 1'b0, 1'b0);
        applyStimulus(8'h0B, 8'h00, 1, 0, 1'b0, 1'b0);

        applyStimulus(8'h0B, 8'hFF, 2, 0, 1'b0, 1'b0);
        tx_data = {8'hA1, 8'hB2, 8'hC3};
        applyStimulus(8'h0A, 8'h2B, 3, 0, 1'b0, 1'b0);

        // ss held low through reset release: the following clocks must not start a frame.
        ss = 1'b0;
        frame_is_read = 1'b0;
        resetDut();
        op = 8'h0A;
        a = 8'h2C;
        for (int b = 7; b >= 0; b--) sendBit(op[b]);
        for (int b = 7; b >= 0; b--) sendBit(a[b]);
        for (int b = 7; b >= 0; b--) sendBit(~a[b]);
        repeat (HALF) @(negedge clk);
        ss = 1'b1;
        repeat (3 * HALF) @(negedge clk);
        checkOutput("ss_low_rst_filter", 32'(filter_ctl), 32'h13);
        checkOutput("ss_low_rst_power", 32'(power_ctl), 32'h00);

        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 9);
            op = (r < 4) ? 8'h0A : (r < 8) ? 8'h0B : 8'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : addrs[$urandom_range(0, 7)];
            x_sample = 8'($urandom);
            y_sample = 8'($urandom);
            applyStimulus(op, a, $urandom_range(1, 3),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0,
                          1'b0, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
